// File: rtl/jellyvl_synctimer_lock_ctl.sv
// Synctimer lock controller: turns raw sync samples into override or tracking
// corrections for the adjust block, and keeps lock status with hysteresis and
// a sync-loss watchdog.
module jellyvl_synctimer_lock_ctl #(
    parameter int TIMER_WIDTH   = 64,
    parameter int CALC_WIDTH    = 32,
    parameter int PHASE_WIDTH   = 32,
    parameter int COUNT_WIDTH   = 8,
    parameter int TIMEOUT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [PHASE_WIDTH-1:0]   param_phase_threshold,
    input  logic [COUNT_WIDTH-1:0]   param_lock_count,
    input  logic [COUNT_WIDTH-1:0]   param_unlock_count,
    input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
    input  logic [TIMER_WIDTH-1:0]   local_time,
    input  logic [TIMER_WIDTH-1:0]   sync_time,
    input  logic                     sync_valid,
    output logic                     correct_override,
    output logic [TIMER_WIDTH-1:0]   correct_time,
    output logic                     correct_valid,
    output logic                     status_locked,
    output logic [1:0]               status_state
);

    localparam int CMP_WIDTH = (CALC_WIDTH + 1 > PHASE_WIDTH) ? CALC_WIDTH + 1 : PHASE_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t                   state;
    logic [COUNT_WIDTH-1:0]   good_cnt;
    logic [COUNT_WIDTH-1:0]   bad_cnt;
    logic [TIMEOUT_WIDTH-1:0] wd_cnt;

    logic [CALC_WIDTH-1:0]    err;
    logic [CALC_WIDTH:0]      err_ext;
    logic [CALC_WIDTH:0]      err_abs;
    logic                     err_min;
    logic                     sample_good;
    logic [COUNT_WIDTH-1:0]   good_inc;
    logic [COUNT_WIDTH-1:0]   bad_inc;
    logic [COUNT_WIDTH-1:0]   lock_lim;
    logic [COUNT_WIDTH-1:0]   unlock_lim;
    logic [TIMEOUT_WIDTH-1:0] wd_inc;
    logic                     timeout_hit;

    // Phase error on the low timer bits, sample quality, saturating counter increments and limits
    always_comb begin
        err         = sync_time[CALC_WIDTH-1:0] - local_time[CALC_WIDTH-1:0];
        err_ext     = {err[CALC_WIDTH-1], err};
        err_abs     = err[CALC_WIDTH-1] ? (~err_ext + (CALC_WIDTH+1)'(1)) : err_ext;
        err_min     = err[CALC_WIDTH-1] && (err[CALC_WIDTH-2:0] == '0);
        sample_good = !err_min && (CMP_WIDTH'(err_abs) <= CMP_WIDTH'(param_phase_threshold));
        good_inc    = (good_cnt == '1) ? good_cnt : good_cnt + COUNT_WIDTH'(1);
        bad_inc     = (bad_cnt == '1) ? bad_cnt : bad_cnt + COUNT_WIDTH'(1);
        lock_lim    = (param_lock_count == '0) ? COUNT_WIDTH'(1) : param_lock_count;
        unlock_lim  = (param_unlock_count == '0) ? COUNT_WIDTH'(1) : param_unlock_count;
        wd_inc      = (wd_cnt == '1) ? wd_cnt : wd_cnt + TIMEOUT_WIDTH'(1);
        timeout_hit = (param_timeout != '0) && (wd_cnt >= param_timeout);
    end

    assign status_state = state;

    // Lock state machine with registered correction strobe, override flag, time and lock status
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            good_cnt         <= '0;
            bad_cnt          <= '0;
            wd_cnt           <= '0;
            correct_valid    <= 1'b0;
            correct_override <= 1'b0;
            correct_time     <= '0;
            status_locked    <= 1'b0;
        end else begin
            correct_valid    <= 1'b0;
            correct_override <= 1'b0;
            wd_cnt           <= wd_inc;
            if (!enable) begin
                state         <= IDLE;
                good_cnt      <= '0;
                bad_cnt       <= '0;
                wd_cnt        <= '0;
                status_locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= ACQUIRE;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                        wd_cnt   <= '0;
                    end
                    ACQUIRE: begin
                        if (sync_valid) begin
                            correct_valid    <= 1'b1;
                            correct_override <= 1'b1;
                            correct_time     <= sync_time;
                            good_cnt         <= '0;
                            wd_cnt           <= '0;
                            state            <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (sync_valid) begin
                            correct_valid <= 1'b1;
                            correct_time  <= sync_time;
                            wd_cnt        <= '0;
                            if (sample_good) begin
                                good_cnt <= good_inc;
                                if (good_inc >= lock_lim) begin
                                    state         <= LOCKED;
                                    bad_cnt       <= '0;
                                    status_locked <= 1'b1;
                                end
                            end else begin
                                correct_override <= 1'b1;
                                good_cnt         <= '0;
                            end
                        end else if (timeout_hit) begin
                            state  <= ACQUIRE;
                            wd_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (sync_valid) begin
                            correct_valid <= 1'b1;
                            correct_time  <= sync_time;
                            wd_cnt        <= '0;
                            if (sample_good) begin
                                bad_cnt <= '0;
                            end else if (bad_inc >= unlock_lim) begin
                                correct_override <= 1'b1;
                                good_cnt         <= '0;
                                bad_cnt          <= '0;
                                state            <= TRACK;
                                status_locked    <= 1'b0;
                            end else begin
                                bad_cnt <= bad_inc;
                            end
                        end else if (timeout_hit) begin
                            state         <= ACQUIRE;
                            wd_cnt        <= '0;
                            status_locked <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jellyvl_synctimer_lock_ctl.sv
// Directed bench for the synctimer lock controller: acquisition, lock and
// unlock hysteresis, watchdog, error wrap and threshold edges, enable and reset.
module tb_jellyvl_synctimer_lock_ctl;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] param_phase_threshold;
    logic [7:0]  param_lock_count;
    logic [7:0]  param_unlock_count;
    logic [31:0] param_timeout;
    logic [63:0] local_time;
    logic [63:0] sync_time;
    logic        sync_valid;
    logic        correct_override;
    logic [63:0] correct_time;
    logic        correct_valid;
    logic        status_locked;
    logic [1:0]  status_state;

    int total;
    int bad;

    localparam logic [63:0] BASE = 64'h1234_5678_1000_0000;

    jellyvl_synctimer_lock_ctl dut (
        .clk                   (clk),
        .reset                 (reset),
        .enable                (enable),
        .param_phase_threshold (param_phase_threshold),
        .param_lock_count      (param_lock_count),
        .param_unlock_count    (param_unlock_count),
        .param_timeout         (param_timeout),
        .local_time            (local_time),
        .sync_time             (sync_time),
        .sync_valid            (sync_valid),
        .correct_override      (correct_override),
        .correct_time          (correct_time),
        .correct_valid         (correct_valid),
        .status_locked         (status_locked),
        .status_state          (status_state)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one single-cycle sync sample with the given raw times and lands one cycle later
    task automatic send_raw(input logic [63:0] lt, input logic [63:0] st);
        local_time = lt;
        sync_time  = st;
        sync_valid = 1'b1;
        tick(1);
        sync_valid = 1'b0;
    endtask

    // Sync sample whose low-32 phase error equals err
    task automatic send_sync(input logic [31:0] err);
        send_raw(BASE, BASE + {{32{err[31]}}, err});
    endtask

    task automatic check_emit(input string tag, input logic ov, input logic [1:0] st);
        check_output({tag, "_valid"}, 64'(correct_valid), 64'd1);
        check_output({tag, "_ovr"}, 64'(correct_override), 64'(ov));
        check_output({tag, "_state"}, 64'(status_state), 64'(st));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        enable = 1'b0;
        param_phase_threshold = 32'd10;
        param_lock_count      = 8'd3;
        param_unlock_count    = 8'd2;
        param_timeout         = 32'd0;
        local_time = '0;
        sync_time  = '0;
        sync_valid = 1'b0;
        tick(3);

        check_output("rst_valid", 64'(correct_valid), 64'd0);
        check_output("rst_ovr", 64'(correct_override), 64'd0);
        check_output("rst_time", correct_time, 64'd0);
        check_output("rst_locked", 64'(status_locked), 64'd0);
        check_output("rst_state", 64'(status_state), 64'd0);

        reset = 1'b0;
        tick(1);
        check_output("idle_state", 64'(status_state), 64'd0);
        enable = 1'b1;
        tick(1);
        check_output("acq_state", 64'(status_state), 64'd1);

        // Acquisition and lock: errors +500,+2,-3,+1
        send_sync(32'd500);
        check_emit("lk1", 1'b1, 2'd2);
        check_output("lk1_time", correct_time, BASE + 64'd500);
        send_sync(32'd2);
        check_emit("lk2", 1'b0, 2'd2);
        send_sync(-32'sd3);
        check_emit("lk3", 1'b0, 2'd2);
        check_output("lk3_time", correct_time, BASE - 64'd3);
        send_sync(32'd1);
        check_emit("lk4", 1'b0, 2'd3);
        check_output("lk4_locked", 64'(status_locked), 64'd1);
        tick(1);
        check_output("idle_valid", 64'(correct_valid), 64'd0);
        check_output("idle_ovr", 64'(correct_override), 64'd0);

        // Unlock hysteresis: +50,+1,+50,+50 with unlock_count=2
        send_sync(32'd50);
        check_emit("ul1", 1'b0, 2'd3);
        send_sync(32'd1);
        check_emit("ul2", 1'b0, 2'd3);
        send_sync(32'd50);
        check_emit("ul3", 1'b0, 2'd3);
        send_sync(32'd50);
        check_emit("ul4", 1'b1, 2'd2);
        check_output("ul4_locked", 64'(status_locked), 64'd0);

        // Relock, then watchdog expiry after 100 quiet cycles
        send_sync(32'd1);
        send_sync(32'd1);
        send_sync(32'd1);
        check_output("rl_state", 64'(status_state), 64'd3);
        param_timeout = 32'd100;
        tick(80);
        check_output("wd_early_state", 64'(status_state), 64'd3);
        tick(40);
        check_output("wd_state", 64'(status_state), 64'd1);
        check_output("wd_locked", 64'(status_locked), 64'd0);
        check_output("wd_valid", 64'(correct_valid), 64'd0);
        send_sync(32'd3);
        check_emit("wd_next", 1'b1, 2'd2);

        // Sync coinciding with an expired watchdog wins and clears it
        param_timeout = 32'd0;
        send_sync(32'd1);
        send_sync(32'd1);
        send_sync(32'd1);
        check_output("co_lock_state", 64'(status_state), 64'd3);
        tick(20);
        param_timeout = 32'd5;
        send_sync(32'd1);
        check_emit("co_sync", 1'b0, 2'd3);
        tick(2);
        check_output("co_cleared_state", 64'(status_state), 64'd3);
        tick(15);
        check_output("co_expire_state", 64'(status_state), 64'd1);
        param_timeout = 32'd0;

        // Low-32 wrap: err = 5 - 0xFFFFFFF0 = +21
        send_sync(32'd0);
        check_emit("wr_acq", 1'b1, 2'd2);
        param_phase_threshold = 32'd21;
        send_raw(64'h0000_0000_FFFF_FFF0, 64'h0000_0001_0000_0005);
        check_emit("wr_thr21", 1'b0, 2'd2);
        check_output("wr_time", correct_time, 64'h0000_0001_0000_0005);
        param_phase_threshold = 32'd20;
        send_raw(64'h0000_0000_FFFF_FFF0, 64'h0000_0001_0000_0005);
        check_emit("wr_thr20", 1'b1, 2'd2);
        param_phase_threshold = 32'hFFFF_FFFF;
        send_sync(32'h8000_0000);
        check_emit("most_neg", 1'b1, 2'd2);
        param_phase_threshold = 32'd10;

        // Enable dropped with a sync in the same cycle
        enable = 1'b0;
        send_sync(32'd1);
        check_output("en_valid", 64'(correct_valid), 64'd0);
        check_output("en_state", 64'(status_state), 64'd0);
        enable = 1'b1;
        tick(1);
        send_sync(32'd1);
        send_sync(32'd1);
        send_sync(32'd1);
        send_sync(32'd1);
        check_output("re_state", 64'(status_state), 64'd3);

        // Reset while locked
        reset = 1'b1;
        tick(1);
        check_output("rl_rst_valid", 64'(correct_valid), 64'd0);
        check_output("rl_rst_ovr", 64'(correct_override), 64'd0);
        check_output("rl_rst_time", correct_time, 64'd0);
        check_output("rl_rst_locked", 64'(status_locked), 64'd0);
        check_output("rl_rst_state", 64'(status_state), 64'd0);
        reset = 1'b0;

        // lock_count=0 behaves as 1
        param_lock_count = 8'd0;
        tick(1);
        send_sync(32'd7);
        check_emit("lc0_acq", 1'b1, 2'd2);
        send_sync(32'd2);
        check_emit("lc0_lock", 1'b0, 2'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] run time bound expired");
    end

endmodule
